// File: rtl/reg_wb_buffer.sv
// In-order writeback queue feeding the register file write port, with two bypass lookups.
// Optional feature macro REG_WB_BYPASS_EN builds the bypass comparators; otherwise hits/data are tied to 0.
module reg_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int AW    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       drain_en,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_wa,
  output logic [DW-1:0]              rf_wd,
  input  logic [AW-1:0]              RA1,
  input  logic [AW-1:0]              RA2,
  output logic                       byp1_hit,
  output logic [DW-1:0]              byp1_data,
  output logic                       byp2_hit,
  output logic [DW-1:0]              byp2_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_t;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  occ_t          occ;
  logic          push;
  logic          pop;

  // Occupancy is purely a view of count; there is no separate state register.
  always_comb begin
    occ = PARTIAL;
    if (count == '0)
      occ = EMPTY;
    else if (count == CW'(DEPTH))
      occ = FULL;
  end

  assign in_ready = (occ != FULL);
  assign rf_we    = (occ != EMPTY) && drain_en;
  assign push     = in_valid && in_ready;
  assign pop      = rf_we;
  assign rf_wa    = rf_we ? mem_addr[rd_ptr] : '0;
  assign rf_wd    = rf_we ? mem_data[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_addr[wr_ptr] <= in_addr;
        mem_data[wr_ptr] <= in_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef REG_WB_BYPASS_EN
  // Walk oldest to youngest so a later match overrides; the youngest match wins.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] ra);
    logic [DW:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (mem_addr[idx] == ra))
        res = {1'b1, mem_data[idx]};
    end
    return res;
  endfunction

  always_comb begin
    {byp1_hit, byp1_data} = lookup(RA1);
    {byp2_hit, byp2_data} = lookup(RA2);
  end
`else
  assign byp1_hit  = 1'b0;
  assign byp1_data = '0;
  assign byp2_hit  = 1'b0;
  assign byp2_data = '0;
`endif

endmodule

// File: tb/tb_reg_wb_buffer.sv
// Bench for reg_wb_buffer: directed scenarios then random traffic against a queue-based reference model.
module tb_reg_wb_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          drain_en;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [AW-1:0] RA1, RA2;
  logic          byp1_hit, byp2_hit;
  logic [DW-1:0] byp1_data, byp2_data;
  logic [2:0]    count;

  reg_wb_buffer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .RA1(RA1), .RA2(RA2),
    .byp1_hit(byp1_hit), .byp1_data(byp1_data),
    .byp2_hit(byp2_hit), .byp2_data(byp2_data),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  ent_t wlog[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Newest queued value for an address; bypass is absent in the default build.
  function automatic void mlook(input logic [AW-1:0] ra, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
`ifdef REG_WB_BYPASS_EN
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].addr == ra) begin
        h = 1'b1;
        d = q[i].data;
        break;
      end
    end
`endif
  endfunction

  // Compare all outputs for the inputs currently applied, then clock once and advance the model.
  task automatic cyc();
    logic          e_we, h1, h2, do_push, do_pop;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd, d1, d2;
    #1;
    e_we = (q.size() != 0) && drain_en;
    e_wa = e_we ? q[0].addr : '0;
    e_wd = e_we ? q[0].data : '0;
    mlook(RA1, h1, d1);
    mlook(RA2, h2, d2);
    check_eq("count",     32'(count),     32'(q.size()));
    check_eq("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
    check_eq("rf_we",     32'(rf_we),     32'(e_we));
    check_eq("rf_wa",     32'(rf_wa),     32'(e_wa));
    check_eq("rf_wd",     32'(rf_wd),     32'(e_wd));
    check_eq("byp1_hit",  32'(byp1_hit),  32'(h1));
    check_eq("byp1_data", 32'(byp1_data), 32'(d1));
    check_eq("byp2_hit",  32'(byp2_hit),  32'(h2));
    check_eq("byp2_data", 32'(byp2_data), 32'(d2));
    if (rf_we) wlog.push_back('{rf_wa, rf_wd});
    do_push = in_valid && (q.size() != DEPTH);
    do_pop  = e_we;
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back('{in_addr, in_data});
    end
    @(negedge clk);
  endtask

  task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  ent_t exp4[5];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_en = 1'b0; RA1 = '0; RA2 = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with a pending push request
    in_valid = 1'b1; in_addr = 4'd2; in_data = 16'hDEAD;
    cyc();
    cyc();
    #1;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0; in_valid = 1'b0;

    // Single write, visible on the write port the following cycle
    drain_en = 1'b1;
    push1(4'd8, 16'h8A37);
    #1;
    check_eq("t2_we", 32'(rf_we), 32'd1);
    check_eq("t2_wa", 32'(rf_wa), 32'd8);
    check_eq("t2_wd", 32'(rf_wd), 32'h8A37);
    cyc();
    cyc();
    wlog.delete();

    // Fill to FULL, bypass picks youngest match
    drain_en = 1'b0;
    push1(4'd8,  16'h1111);
    push1(4'd15, 16'h2222);
    push1(4'd8,  16'h3333);
    push1(4'd5,  16'h4444);
    RA1 = 4'd8; RA2 = 4'd1;
    #1;
    check_eq("t3_count", 32'(count), 32'd4);
    check_eq("t3_ready", 32'(in_ready), 32'd0);
`ifdef REG_WB_BYPASS_EN
    check_eq("t3_b1hit", 32'(byp1_hit), 32'd1);
    check_eq("t3_b1dat", 32'(byp1_data), 32'h3333);
`else
    check_eq("t3_b1hit", 32'(byp1_hit), 32'd0);
`endif
    check_eq("t3_b2hit", 32'(byp2_hit), 32'd0);
    check_eq("t3_b2dat", 32'(byp2_data), 32'd0);
    cyc();

    // Drain from FULL with a waiting producer; order must be preserved across wrap
    drain_en = 1'b1;
    in_valid = 1'b1; in_addr = 4'd3; in_data = 16'h5555;
    #1;
    check_eq("t4_noacc", 32'(in_ready), 32'd0);
    cyc();
    #1;
    check_eq("t4_acc", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    exp4[0] = '{4'd8, 16'h1111}; exp4[1] = '{4'd15, 16'h2222};
    exp4[2] = '{4'd8, 16'h3333}; exp4[3] = '{4'd5, 16'h4444};
    exp4[4] = '{4'd3, 16'h5555};
    check_eq("t4_nwr", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < wlog.size()) check_eq("t4_seq", 32'(wlog[i]), 32'(exp4[i]));

    // Simultaneous push/pop at count 2; popped head still searched
    drain_en = 1'b0;
    push1(4'd6, 16'hAAAA);
    push1(4'd7, 16'hBBBB);
    drain_en = 1'b1; RA1 = 4'd6;
    in_valid = 1'b1; in_addr = 4'd9; in_data = 16'hCCCC;
    #1;
`ifdef REG_WB_BYPASS_EN
    check_eq("t5_b1hit", 32'(byp1_hit), 32'd1);
`else
    check_eq("t5_b1hit", 32'(byp1_hit), 32'd0);
`endif
    cyc();
    in_valid = 1'b0; drain_en = 1'b0;
    #1;
    check_eq("t5_count", 32'(count), 32'd2);
    cyc();

    // Reset mid-operation discards pending entries
    push1(4'd1, 16'h0101);
    reset = 1'b1;
    cyc();
    reset = 1'b0; drain_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      RA1 = AW'(a);
      cyc();
    end

    // Random traffic, narrow address range to exercise duplicate matches
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      drain_en = ($urandom_range(0, 2) != 0);
      in_addr  = AW'($urandom_range(0, 3));
      in_data  = DW'($urandom);
      RA1      = AW'($urandom_range(0, 4));
      RA2      = AW'($urandom_range(0, 4));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_wb_buffer.md
# reg_wb_buffer

Writeback buffer on the write side of the 16-register file in the 16-bit RISC datapath. Accepts results from the execute and memory stages over a valid/ready handshake and queues them in order. Drains one entry per cycle into the register file write port (`WA`, `data_in`, `write_enable`). Provides two bypass lookups, so operand reads see queued results that have not yet been written.

## Interface

Parameters:
- `DEPTH`, 4, number of queued writes (power of two, ≥2)
- `DW`, 16, data word width
- `AW`, 4, register address width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  producer has a result to write
- `in_ready`  out  1  buffer can accept this cycle
- `in_addr`  in  AW  destination register of result
- `in_data`  in  DW  result value
- `drain_en`  in  1  permit writing head entry to register file this cycle
- `rf_we`  out  1  register file write enable
- `rf_wa`  out  AW  register file write address
- `rf_wd`  out  DW  register file write data
- `RA1`  in  AW  read address, port 1 (same address the register file sees)
- `RA2`  in  AW  read address, port 2
- `byp1_hit`  out  1  pending write to `RA1` exists in buffer
- `byp1_data`  out  DW  newest pending value for `RA1`
- `byp2_hit`  out  1  pending write to `RA2` exists
- `byp2_data`  out  DW  newest pending value for `RA2`
- `count`  out  $clog2(DEPTH+1)  number of valid entries

## Operation

- Circular FIFO: `DEPTH` entries of {addr, data}, write pointer, read pointer, occupancy `count`.
- Occupancy state is derived from `count`:
  - EMPTY when `count`=0
  - PARTIAL when 0<`count`<DEPTH
  - FULL when `count`=DEPTH
- Transitions follow push/pop below. There is no other state.
- Push: `in_valid && in_ready` at edge → entry stored at write pointer; write pointer +1 mod DEPTH.
- `in_ready` = (`count` != DEPTH). It is combinational from registered `count` and does not depend on same-cycle pop.
- Pop: `rf_we` = (`count` != 0) && `drain_en`. When `rf_we`=1, the head entry drives `rf_wa`/`rf_wd`. At the edge the read pointer advances by 1 mod DEPTH.
- When `rf_we`=0, `rf_wa` and `rf_wd` are driven to 0.
- Simultaneous push and pop: `count` unchanged, both pointers advance.
- Push when EMPTY: no same-cycle pass-through. The entry reaches `rf_we` no earlier than the next cycle.
- Pointer wrap: the pointer wraps from DEPTH-1 to 0 with no gap.
- Bypass: compare `RA1`/`RA2` against all valid entries.
  - The hit selects the youngest matching entry (closest to the write pointer).
  - On a miss, hit=0 and data=0.
  - The entry being pushed this cycle is not searched.
  - The head entry being popped this cycle is still searched.
- Duplicate addresses are permitted. Entries are never coalesced, and all are written in order.
- Register 0 gets no special treatment.

## Timing

- Reset (edge with `reset`=1):
  - `count`=0, pointers=0, all entries invalid.
  - Next cycle: `in_ready`=1, `rf_we`=0, `rf_wa`=0, `rf_wd`=0, `byp1_hit`=`byp2_hit`=0, `byp1_data`=`byp2_data`=0.
- Reset mid-operation: all pending entries are discarded and never written. Reset overrides a push or pop in the same cycle.
- Latency: an accept at edge N gives `rf_we` at earliest in cycle N+1, when the queue was empty and `drain_en`=1.
- Throughput: one push and one pop per cycle.
- The register file samples `rf_we`/`rf_wa`/`rf_wd` on the same edge that pops the entry.
- Bypass outputs are combinational from `RA1`/`RA2` and registered entries, with zero-cycle latency.
- All outputs are glitch-free with respect to `clk` edges. There are no latches.

## Configuration

- Macro: `REG_WB_BYPASS_EN`.
- Defined: bypass comparators and priority select are built as described in Operation.
- Undefined: the comparators are not built. `byp1_hit`=`byp2_hit`=0 and `byp1_data`=`byp2_data`=0 at all times. The hazard unit must then stall reads until `count`=0.
- FIFO and drain behaviour are identical in both builds.

## Test plan

1. Reset check: hold `reset`=1 for 2 cycles with `in_valid`=1 → `count`=0, `in_ready`=1, `rf_we`=0, `rf_wa`=0, `rf_wd`=0, both hits 0.
2. Single write: `drain_en`=1; push addr 8, data 16'h8A37 at edge 0 → cycle 1: `rf_we`=1, `rf_wa`=8, `rf_wd`=16'h8A37; after edge 1, `count`=0 and `rf_we`=0.
3. Fill and bypass:
   - Stimulus: `drain_en`=0; push (8,16'h1111), (15,16'h2222), (8,16'h3333), (5,16'h4444).
   - Then: `count`=4, `in_ready`=0.
   - `RA1`=8 → `byp1_hit`=1, `byp1_data`=16'h3333.
   - `RA2`=1 → `byp2_hit`=0, `byp2_data`=0.
4. Drain order from FULL:
   - Stimulus: from state 3, set `drain_en`=1 with `in_valid` held at 1 (addr 3, data 16'h5555).
   - First cycle: writes 8/1111, no accept.
   - Next cycle: `in_ready`=1, 3/5555 is accepted.
   - Write sequence: 8/1111, 15/2222, 8/3333, 5/4444, 3/5555.
   - Pointers wrap correctly.
5. Simultaneous push/pop: with `count`=2, push and drain in one cycle → `count` stays 2. The popped entry's `RA1` bypass is still hit during that cycle.
6. Reset mid-operation: with `count`=3 and `drain_en`=0, assert `reset` for one cycle → `count`=0, no `rf_we` pulse afterwards, `byp1_hit`=0 for all `RA1`.
